// File: rtl/lvds_gearbox_7to1.sv
// 7:1 parallel-to-serial gearbox for the LVDS panel transmitter.
// A 49-bit time-major word is captured once per RATIO cycles and shifted out one slot per cycle.

module lvds_gb_lane #(
  parameter int RATIO = 7,
  parameter int CW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cap_i,
  input  logic [CW-1:0]    sel_i,
  input  logic [RATIO-1:0] din_i,
  output logic             q_o
);
  logic [RATIO-1:0] w_q;
  logic             q_q;

  // On capture, slot 0 goes straight to q so words run back-to-back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q <= '0;
      q_q <= 1'b0;
    end else if (cap_i) begin
      w_q <= din_i;
      q_q <= din_i[0];
    end else begin
      q_q <= w_q[sel_i];
    end
  end

  assign q_o = q_q;
endmodule

module lvds_gearbox_7to1 #(
  parameter int LANES = 7,
  parameter int RATIO = 7
) (
  input  logic                   fclk,
  input  logic                   reset,
  input  logic [LANES*RATIO-1:0] din,
  output logic                   load,
  output logic [LANES-1:0]       q
);
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [CW-1:0]                   slot_nxt;
  logic [LANES-1:0][RATIO-1:0]     lane_din;

  assign slot_nxt = cnt_q + CW'(1);
  assign load     = (cnt_q == CW'(RATIO-1)) & ~reset;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = '0;
    else      cnt_d = slot_nxt;
  end

  always_ff @(posedge fclk) begin
    if (reset) cnt_q <= CW'(RATIO-1);
    else       cnt_q <= cnt_d;
  end

  // Regroup the time-major word into one RATIO-bit slot vector per lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar t = 0; t < RATIO; t++) begin : g_slot
      assign lane_din[l][t] = din[LANES*t + l];
    end

    lvds_gb_lane #(
      .RATIO (RATIO),
      .CW    (CW)
    ) u_lane (
      .clk_i (fclk),
      .rst_i (reset),
      .cap_i (load),
      .sel_i (slot_nxt),
      .din_i (lane_din[l]),
      .q_o   (q[l])
    );
  end
endmodule

// File: tb/tb_lvds_gearbox_7to1.sv
// Randomized/directed bench for lvds_gearbox_7to1 with a slot-queue reference model and scoreboard.

module tb_lvds_gearbox_7to1;
  logic        fclk = 1'b0;
  logic        rst  = 1'b1;
  logic [48:0] din  = '1;
  logic        load;
  logic [6:0]  q;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  typedef struct packed {
    logic       ld;
    logic [6:0] q;
  } exp_t;

  exp_t sb[$];

  lvds_gearbox_7to1 #(.LANES(7), .RATIO(7)) dut (
    .fclk  (fclk),
    .reset (rst),
    .din   (din),
    .load  (load),
    .q     (q)
  );

  always #5 fclk = ~fclk;

  // Reference: a word becomes seven pending slots; one slot leaves per edge,
  // and a new word is taken only when nothing is pending. Reset drops everything.
  initial begin
    logic [6:0]  slots[$];
    bit          prst;
    logic [48:0] pdin;
    logic [6:0]  eq;
    exp_t        e;
    prst = 1'b1;
    pdin = '0;
    forever begin
      @(posedge fclk);
      if (prst) begin
        slots.delete();
        eq = '0;
      end else begin
        if (slots.size() == 0)
          for (int t = 0; t < 7; t++) slots.push_back(pdin[7*t +: 7]);
        eq = slots.pop_front();
      end
      #2;
      prst = rst;
      pdin = din;
      e.ld = !rst && (slots.size() == 0);
      e.q  = eq;
      sb.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents q and load; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge fclk);
      if (done) break;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: no expected entry at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (q !== e.q) begin
          failures++;
          $display("FAIL q: t=%0t got=%h exp=%h", $time, q, e.q);
        end
        checks++;
        if (load !== e.ld) begin
          failures++;
          $display("FAIL load: t=%0t got=%b exp=%b", $time, load, e.ld);
        end
      end
    end
  end

  task automatic cyc(input bit r, input logic [48:0] d);
    @(posedge fclk);
    #1;
    rst = r;
    din = d;
  endtask

  initial begin
    logic [48:0] w;
    logic [48:0] clk_pat;
    logic [48:0] cntv;
    // Reset held with din all ones, then release.
    for (int i = 0; i < 3; i++) cyc(1'b1, '1);
    for (int i = 0; i < 14; i++) cyc(1'b0, '1);

    // Clock-lane pattern 1100011 on lane 0.
    clk_pat = '0;
    clk_pat[0] = 1'b1; clk_pat[7] = 1'b1; clk_pat[35] = 1'b1; clk_pat[42] = 1'b1;
    cyc(1'b1, clk_pat);
    for (int i = 0; i < 21; i++) cyc(1'b0, clk_pat);

    // Walking bit, aligned by a reset so each word spans exactly 7 cycles.
    cyc(1'b1, '0);
    for (int k = 0; k < 49; k++) begin
      w = 49'd1 << k;
      for (int i = 0; i < 7; i++) cyc(1'b0, w);
    end

    // Back-to-back alternating zero / all-ones words.
    for (int k = 0; k < 10; k++) begin
      w = (k % 2) ? 49'h1_FFFF_FFFF_FFFF : 49'h0;
      for (int i = 0; i < 7; i++) cyc(1'b0, w);
    end

    // Counter on din every cycle for 100 words: only load-edge values appear.
    cntv = 49'h1_2345_0000_0000;
    for (int i = 0; i < 700; i++) begin
      cyc(1'b0, cntv);
      cntv = cntv + 49'h0_0001_0203_0405;
    end

    // Mid-word reset for one cycle, then release with fresh data.
    cyc(1'b1, '0);
    for (int i = 0; i < 4; i++) cyc(1'b0, {$urandom, $urandom});
    cyc(1'b1, '1);
    for (int i = 0; i < 14; i++) cyc(1'b0, {17'($urandom), $urandom});

    // Random data with sporadic resets.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 29) == 0), {17'($urandom), $urandom});

    repeat (3) @(posedge fclk);
    #1 done = 1'b1;
    @(negedge fclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
